// File: rtl/csa_mul_pkg.sv
// csa_mul_pkg: shared types and helpers for the radix-4 Booth CSA multiplier
// sequencer (op encodings, FSM states, Booth digit decode, iteration counts).
package csa_mul_pkg;

    typedef enum logic [1:0] {
        MULOP_MUL    = 2'b00,  // low half, sign irrelevant
        MULOP_MULH   = 2'b01,  // high half, signed x signed
        MULOP_MULHSU = 2'b10,  // high half, signed x unsigned
        MULOP_MULHU  = 2'b11   // high half, unsigned x unsigned
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FINAL = 2'b10,
        ST_DONE  = 2'b11
    } mul_state_e;

    // One radix-4 Booth digit in {-2..+2}: magnitude one-hot (one/two) plus sign
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic int booth_digits(input int data_width);
        return data_width / 2 + 1;
    endfunction

    function automatic int booth_iter(input int data_width);
        return (booth_digits(data_width) + 1) / 2;
    endfunction

    function automatic logic op_rs1_signed(input mul_op_e op);
        return op != MULOP_MULHU;
    endfunction

    function automatic logic op_rs2_signed(input mul_op_e op);
        return (op == MULOP_MUL) || (op == MULOP_MULH);
    endfunction

    // Window {b[i+1], b[i], b[i-1]} -> digit = -2*b[i+1] + b[i] + b[i-1]
    function automatic booth_digit_t booth_decode(input logic [2:0] window);
        booth_digit_t d;
        d.neg = window[2] & ~(window[1] & window[0]);
        d.one = window[1] ^ window[0];
        d.two = (window == 3'b011) || (window == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/CasAdder4_2.sv
// CasAdder4_2: 4:2 carry-save compressor built from two 3:2 levels.
// Sum + Carry == In0 + In1 + In2 + In3 modulo 2^Width (top carries dropped).
module CasAdder4_2 #(
    parameter int Width = 128
) (
    input  logic [Width-1:0] In0,
    input  logic [Width-1:0] In1,
    input  logic [Width-1:0] In2,
    input  logic [Width-1:0] In3,
    output logic [Width-1:0] Sum,
    output logic [Width-1:0] Carry
);

    logic [Width-1:0] s1;
    logic [Width-1:0] c1;

    // Two cascaded full-adder rows; carries shift up one bit and the MSB carry falls off
    always_comb begin
        s1    = In0 ^ In1 ^ In2;
        c1    = ((In0 & In1) | (In0 & In2) | (In1 & In2)) << 1;
        Sum   = s1 ^ In3 ^ c1;
        Carry = ((s1 & In3) | (s1 & c1) | (In3 & c1)) << 1;
    end

endmodule

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth partial product, digit * mcand, as a full
// two's-complement value of the accumulator width.
module booth_pp_gen
    import csa_mul_pkg::*;
#(
    parameter int Width = 128
) (
    input  logic [2:0]       window,
    input  logic [Width-1:0] mcand,
    output logic [Width-1:0] pp
);

    booth_digit_t     digit;
    logic [Width-1:0] mag;

    // Pick |digit| * mcand, then negate as invert plus an LSB +1 folded into the product
    always_comb begin
        digit = booth_decode(window);
        mag   = '0;
        if (digit.one) begin
            mag = mcand;
        end else if (digit.two) begin
            mag = mcand << 1;
        end
        pp = digit.neg ? (~mag + Width'(1)) : mag;
    end

endmodule

// File: rtl/csa_mul_sequencer.sv
// csa_mul_sequencer: iterative radix-4 Booth multiplier for RV64M MUL/MULH/
// MULHSU/MULHU. Two Booth digits per CALC cycle are folded into a carry-save
// Sum/Carry pair; FINAL resolves the pair with one carry-propagate add.
// Optional build macro MUL_EARLY_OUT_EN: leave CALC as soon as the remaining
// multiplier bits are pure sign extension (all later digits are zero).
module csa_mul_sequencer
    import csa_mul_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [1:0]           MulOp,
    input  logic [DataWidth-1:0] Multiplicand,
    input  logic [DataWidth-1:0] Multiplier,
    input  logic                 Flush,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataWidth-1:0] Result,
    output logic                 Busy
);

    localparam int BoothDigits = booth_digits(DataWidth);
    localparam int Iter        = booth_iter(DataWidth);
    localparam int ProdWidth   = 2 * DataWidth;
    localparam int MplrWidth   = DataWidth + 3;  // 2 extension bits + operand + implicit bit -1
    localparam int CntWidth    = $clog2(Iter + 1);

    mul_state_e             state_q, state_d;
    mul_op_e                op_q, op_d;
    logic [ProdWidth-1:0]   mcand_q, mcand_d;
    logic [ProdWidth-1:0]   acc_sum_q, acc_sum_d;
    logic [ProdWidth-1:0]   acc_carry_q, acc_carry_d;
    logic [MplrWidth-1:0]   mplr_q, mplr_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic [DataWidth-1:0]   result_q, result_d;

    logic [2:0]             win0, win1;
    logic [ProdWidth-1:0]   mcand_x4;
    logic [ProdWidth-1:0]   pp0, pp1;
    logic [ProdWidth-1:0]   cmp_sum, cmp_carry;
    logic [ProdWidth-1:0]   product;
    logic [MplrWidth-1:0]   mplr_shift;
    logic                   rs1_sign, rs2_sign;
    logic                   early_out;

    assign rs1_sign   = op_rs1_signed(mul_op_e'(MulOp)) & Multiplicand[DataWidth-1];
    assign rs2_sign   = op_rs2_signed(mul_op_e'(MulOp)) & Multiplier[DataWidth-1];
    assign mcand_x4   = {mcand_q[ProdWidth-3:0], 2'b00};
    assign mplr_shift = {{4{mplr_q[MplrWidth-1]}}, mplr_q[MplrWidth-1:4]};
    assign product    = acc_sum_q + acc_carry_q;

`ifdef MUL_EARLY_OUT_EN
    // Remaining bits all equal to the sign means every later Booth digit is zero
    assign early_out = (&mplr_shift) | ~(|mplr_shift);
`else
    assign early_out = 1'b0;
`endif

    // Present the two lowest Booth windows, zeroing digits past the last real one
    always_comb begin
        win0 = mplr_q[2:0];
        win1 = mplr_q[4:2];
        if ((2 * int'(cnt_q)) >= BoothDigits) begin
            win0 = 3'b000;
        end
        if ((2 * int'(cnt_q) + 1) >= BoothDigits) begin
            win1 = 3'b000;
        end
    end

    booth_pp_gen #(.Width(ProdWidth)) u_pp0 (
        .window (win0),
        .mcand  (mcand_q),
        .pp     (pp0)
    );

    booth_pp_gen #(.Width(ProdWidth)) u_pp1 (
        .window (win1),
        .mcand  (mcand_x4),
        .pp     (pp1)
    );

    CasAdder4_2 #(.Width(ProdWidth)) u_cmp (
        .In0   (pp0),
        .In1   (pp1),
        .In2   (acc_sum_q),
        .In3   (acc_carry_q),
        .Sum   (cmp_sum),
        .Carry (cmp_carry)
    );

    // Next-state and datapath updates; Flush overrides every other transition
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        acc_sum_d   = acc_sum_q;
        acc_carry_d = acc_carry_q;
        mplr_d      = mplr_q;
        cnt_d       = cnt_q;
        result_d    = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (InValid && !Flush) begin
                    op_d        = mul_op_e'(MulOp);
                    mcand_d     = {{DataWidth{rs1_sign}}, Multiplicand};
                    mplr_d      = {{2{rs2_sign}}, Multiplier, 1'b0};
                    acc_sum_d   = '0;
                    acc_carry_d = '0;
                    cnt_d       = '0;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_sum_d   = cmp_sum;
                acc_carry_d = cmp_carry;
                mcand_d     = mcand_q << 4;
                mplr_d      = mplr_shift;
                cnt_d       = cnt_q + CntWidth'(1);
                if ((cnt_q == CntWidth'(Iter - 1)) || early_out) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                result_d = (op_q == MULOP_MUL) ? product[DataWidth-1:0]
                                               : product[ProdWidth-1:DataWidth];
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (Flush) begin
            state_d = ST_IDLE;
        end

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            op_q        <= MULOP_MUL;
            mcand_q     <= '0;
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            acc_sum_q   <= acc_sum_d;
            acc_carry_q <= acc_carry_d;
            mplr_q      <= mplr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
        end
    end

    // InReady is held low while reset is asserted and rises as soon as it is released
    assign InReady  = in_ready_q & Rst;
    assign OutValid = out_valid_q;
    assign Result   = result_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_csa_mul_sequencer.sv
// tb_csa_mul_sequencer: table vectors, hand-written multi-cycle sequences and
// randomized operations checked against a plain-arithmetic multiply model.
module tb_csa_mul_sequencer;

    localparam int DW   = 64;
    localparam int ITER = 17;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          InValid;
    logic          InReady;
    logic [1:0]    MulOp;
    logic [DW-1:0] Multiplicand;
    logic [DW-1:0] Multiplier;
    logic          Flush;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] Result;
    logic          Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    csa_mul_sequencer #(.DataWidth(DW)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .InValid      (InValid),
        .InReady      (InReady),
        .MulOp        (MulOp),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Flush        (Flush),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Result       (Result),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: OutValid never rose within the cycle budget", name);
    endtask

    // Full-width product of the extended operands, then select the half
    function automatic logic [DW-1:0] ref_mul(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        ea = (op != 2'b11 && a[DW-1]) ? {{DW{1'b1}}, a} : {{DW{1'b0}}, a};
        eb = (op[1] == 1'b0 && b[DW-1]) ? {{DW{1'b1}}, b} : {{DW{1'b0}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[DW-1:0] : p[127:DW];
    endfunction

    // Cycles from accept to OutValid: with early out, stop after k digit pairs
    // once the multiplier value divided by 2^(4k-1) is 0 or -1
    function automatic int exp_lat(input logic [1:0] op, input logic [DW-1:0] b);
        logic signed [71:0] v;
        logic signed [71:0] rem;
        int used;
        v    = (op[1] == 1'b0 && b[DW-1]) ? {8'hFF, b} : {8'h00, b};
        used = ITER;
        for (int k = ITER; k >= 1; k--) begin
            rem = v >>> (4 * k - 1);
            if (rem == '0 || rem == '1) used = k;
        end
`ifdef MUL_EARLY_OUT_EN
        return used + 2;
`else
        return (used > 0) ? ITER + 2 : ITER + 2;
`endif
    endfunction

    function automatic logic [DW-1:0] rand_operand();
        logic [DW-1:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = DW'($urandom_range(0, 4095));
            2: v = -DW'($urandom_range(1, 4095));
            default: begin
                case ($urandom_range(0, 4))
                    0:       v = '0;
                    1:       v = DW'(1);
                    2:       v = '1;
                    3:       v = 64'h8000_0000_0000_0000;
                    default: v = 64'h7FFF_FFFF_FFFF_FFFF;
                endcase
            end
        endcase
        return v;
    endfunction

    // Issue one op, measure latency, optionally stall the consumer, then release
    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp_res, input int stall, input string tag);
        int lat;
        int exp_l;
        exp_l = exp_lat(op, b);
        @(negedge Clk);
        MulOp        = op;
        Multiplicand = a;
        Multiplier   = b;
        InValid      = 1'b1;
        OutReady     = (stall == 0);
        @(negedge Clk);
        InValid = 1'b0;
        lat     = 1;
        while (!OutValid && lat < 200) begin
            @(negedge Clk);
            lat++;
        end
        if (!OutValid) begin
            note_timeout(tag);
            OutReady = 1'b1;
            return;
        end
        check({tag, " result"}, Result, exp_res);
        check({tag, " latency"}, lat, exp_l);
        for (int s = 0; s < stall; s++) begin
            @(negedge Clk);
            check({tag, " hold OutValid"}, OutValid, 1'b1);
            check({tag, " hold Result"}, Result, exp_res);
            check({tag, " hold InReady"}, InReady, 1'b0);
        end
        OutReady = 1'b1;
        @(negedge Clk);
        check({tag, " release OutValid"}, OutValid, 1'b0);
        check({tag, " release InReady"}, InReady, 1'b1);
        check({tag, " release Busy"}, Busy, 1'b0);
    endtask

    initial begin
        int seen;
        int wait_cnt;
        logic [1:0]    rop;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        vecs[0] = '{2'b00, 64'd3, 64'd5, 64'h0F};
        vecs[1] = '{2'b01, '1, '1, 64'h0};
        vecs[2] = '{2'b00, '1, '1, 64'h1};
        vecs[3] = '{2'b11, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4] = '{2'b10, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[6] = '{2'b00, 64'd7, 64'd6, 64'h2A};
        vecs[7] = '{2'b00, 64'd2, 64'd3, 64'h6};

        Rst = 1'b0; InValid = 1'b0; MulOp = 2'b00; Multiplicand = '0; Multiplier = '0;
        Flush = 1'b0; OutReady = 1'b1;

        // Reset state
        #12;
        check("reset InReady", InReady, 1'b0);
        check("reset OutValid", OutValid, 1'b0);
        check("reset Result", Result, 64'h0);
        check("reset Busy", Busy, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("post-reset InReady", InReady, 1'b1);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));
        end

        // Consumer stalls 5 cycles in DONE
        run_op(2'b01, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210,
               ref_mul(2'b01, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210), 5, "stall5");

        // Flush in CALC cycle 7, old result must never appear
        @(negedge Clk);
        MulOp = 2'b00; Multiplicand = 64'h1234_5678_9ABC_DEF1; Multiplier = 64'h7654_3210_FEDC_BA98;
        InValid = 1'b1; OutReady = 1'b1;
        @(negedge Clk);
        InValid = 1'b0;
        repeat (6) @(negedge Clk);
        check("flush pre Busy", Busy, 1'b1);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush OutValid", OutValid, 1'b0);
        check("flush InReady", InReady, 1'b1);
        check("flush Busy", Busy, 1'b0);
        seen = 0;
        repeat (30) begin
            @(negedge Clk);
            if (OutValid) seen++;
        end
        check("flush no result", seen, 0);
        run_op(2'b00, 64'd7, 64'd6, 64'h2A, 0, "after flush");

        // Flush wins over InValid in IDLE
        @(negedge Clk);
        InValid = 1'b1; Flush = 1'b1; Multiplicand = 64'd9; Multiplier = 64'd9;
        @(negedge Clk);
        InValid = 1'b0; Flush = 1'b0;
        check("flush vs InValid InReady", InReady, 1'b1);
        check("flush vs InValid Busy", Busy, 1'b0);

        // Flush in DONE while the consumer is stalled
        @(negedge Clk);
        MulOp = 2'b11; Multiplicand = 64'd11; Multiplier = 64'd13; InValid = 1'b1; OutReady = 1'b0;
        @(negedge Clk);
        InValid  = 1'b0;
        wait_cnt = 1;
        while (!OutValid && wait_cnt < 200) begin
            @(negedge Clk);
            wait_cnt++;
        end
        if (!OutValid) begin
            note_timeout("flush in DONE");
        end else begin
            Flush = 1'b1;
            @(negedge Clk);
            Flush = 1'b0;
            check("flush DONE OutValid", OutValid, 1'b0);
            check("flush DONE InReady", InReady, 1'b1);
        end
        OutReady = 1'b1;

        // Asynchronous reset in the middle of CALC
        @(negedge Clk);
        MulOp = 2'b01; Multiplicand = 64'hDEAD_BEEF_0123_4567; Multiplier = 64'h7777_0000_1111_2222;
        InValid = 1'b1;
        @(negedge Clk);
        InValid = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("mid reset InReady", InReady, 1'b0);
        check("mid reset OutValid", OutValid, 1'b0);
        check("mid reset Result", Result, 64'h0);
        check("mid reset Busy", Busy, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("after mid reset InReady", InReady, 1'b1);
        run_op(2'b00, 64'd100, 64'd25, 64'd2500, 0, "after reset");

        // Randomized operations
        for (int n = 0; n < 1500; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = rand_operand();
            rb  = rand_operand();
            run_op(rop, ra, rb, ref_mul(rop, ra, rb),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                   $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_mul_sequencer.md
Name: csa_mul_sequencer

Overview:
Iterative radix-4 Booth multiplier controller for the ALU. Each cycle it generates two Booth partial products and folds them into a carry-save accumulator (Sum/Carry pair) through the existing 4:2 compressor (CasAdder4_2, width 2*DataWidth). A final cycle resolves Sum+Carry with a carry-propagate add. It serves the RV64M MUL/MULH/MULHSU/MULHU ops via valid/ready handshakes on both sides.

Parameters:
DataWidth, 64, operand width (even, >=8)
BoothDigits, DataWidth/2+1, Booth digits per operation (localparam)
Iter, (BoothDigits+1)/2, CALC cycles per operation (localparam)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous active-low reset
InValid  in  1  request valid
InReady  out  1  block can accept (IDLE only)
MulOp  in  2  00 MUL(low), 01 MULH(s*s), 10 MULHSU(s*u), 11 MULHU(u*u)
Multiplicand  in  DataWidth  rs1
Multiplier  in  DataWidth  rs2
Flush  in  1  cancel in-flight op
OutValid  out  1  result valid
OutReady  in  1  consumer accepts result
Result  out  DataWidth  low or high half per MulOp
Busy  out  1  state != IDLE

Behaviour:
- Reset (Rst low, async): state IDLE; InReady=1 once Rst deasserted, OutValid=0, Result=0, Busy=0; accumulators, shifters and op register cleared.
- States: IDLE -> CALC (on InValid&InReady) -> FINAL (after Iter CALC cycles) -> DONE -> IDLE (on OutValid&OutReady).
- Accept: operands extended to DataWidth+2 bits (sign-extended if signed per MulOp, else zero-extended); multiplicand further sign/zero-extended to 2*DataWidth into McandReg; multiplier stored with implicit bit -1 = 0; AccSum=AccCarry=0; counter=0.
- CALC, each cycle: take the two lowest Booth digits (3-bit overlapping windows) of multiplier register; PP0 = digit0 * McandReg, PP1 = digit1 * (McandReg<<2), digits in {-2..+2}, negation as invert+1 with the +1 injected as a separate LSB term folded into the PP (two's complement, 2*DataWidth wide); {AccSum,AccCarry} <= compressor(PP0, PP1, AccSum, AccCarry); McandReg <<= 4; multiplier >>= 4 (arithmetic, keeping last window bit); counter++. Digits past BoothDigits forced to 0.
- All arithmetic modulo 2^(2*DataWidth); compressor's dropped MSB carry is intended.
- FINAL: Product = AccSum + AccCarry; Result <= MulOp==00 ? Product[DataWidth-1:0] : Product[2*DataWidth-1:DataWidth].
- DONE: OutValid=1, Result held stable until OutReady; back-to-back not supported (InReady=0 outside IDLE).
- Latency: OutValid first high Iter+2 cycles after accept cycle (19 at DataWidth=64).
- Flush: in any state returns to IDLE next cycle, OutValid drops, no result delivered; Flush has priority over OutReady and over InValid in the same cycle.
- Rst mid-operation: immediate abort, all outputs to reset values.

Optional Feature:
MUL_EARLY_OUT_EN: defined -> in CALC, if all remaining multiplier-register bits (including window bit) equal its MSB, all remaining Booth digits are 0, so transition straight to FINAL; latency becomes 2 + cycles actually used (min 3). Undefined -> always exactly Iter CALC cycles; results identical either way.

Decomposition:
- Package csa_mul_pkg: MulOp encodings, state encoding (IDLE/CALC/FINAL/DONE), Booth digit encoding, BoothDigits/Iter functions of DataWidth.
- Sub-module booth_pp_gen: 3-bit window + 2*DataWidth multiplicand -> partial product; two instances. Compressor instantiated directly.

Test Plan:
- MUL 3*5, OutReady=1 -> Result=0x0F, OutValid at cycle 19 after accept, one cycle, back to IDLE.
- MULH -1*-1 -> 0x0; MUL same operands -> 0x1; MULHU 0xFFFF_FFFF_FFFF_FFFF*same -> 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU rs1=-1, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFF; MULH 0x8000_0000_0000_0000*same -> 0x4000_0000_0000_0000.
- OutReady low 5 cycles in DONE -> OutValid and Result stable, InReady=0; release -> IDLE next cycle.
- Flush at CALC cycle 7, then new MUL 7*6 -> old result never appears, Result=0x2A; Rst low mid-CALC -> all outputs 0 immediately.
- MUL_EARLY_OUT_EN: MUL 2*3 -> Result=6 with latency <19; random 10k ops vs reference model with macro on and off.
